// File: rtl/fft_pkg.sv
// Shared FFT definitions: sizing, bit reversal, twiddle constants and types.
package fft_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Complex value wide enough for any supported component width.
    typedef struct packed {
        logic signed [31:0] re;
        logic signed [31:0] im;
    } cplx32_t;

    localparam real PI = 3.14159265358979323846;

    function automatic int log2_int(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int bit_reverse(input int v, input int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) begin
            r = (r << 1) | ((v >> i) & 1);
        end
        return r;
    endfunction

    function automatic int round_real(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else return -$rtoi(-x + 0.5);
    endfunction

    // cos and sin of +2*pi*k/n in Q1.(tw_w-1), full scale 2^(tw_w-1)-1.
    function automatic cplx32_t twiddle(input int k, input int n, input int tw_w);
        cplx32_t t;
        real amp;
        real ang;
        amp  = real'((1 << (tw_w - 1)) - 1);
        ang  = 2.0 * PI * real'(k) / real'(n);
        t.re = round_real(amp * $cos(ang));
        t.im = round_real(amp * $sin(ang));
        return t;
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly with per-stage halving; the twiddle
// is the forward one, conjugated when conj_tw is set (inverse transform).
module fft_butterfly #(
    parameter int WIDTH = 16,
    parameter int TW_W  = 16
) (
    input  logic                    conj_tw,
    input  logic signed [WIDTH-1:0] a_re,
    input  logic signed [WIDTH-1:0] a_im,
    input  logic signed [WIDTH-1:0] b_re,
    input  logic signed [WIDTH-1:0] b_im,
    input  logic signed [TW_W-1:0]  w_re,
    input  logic signed [TW_W-1:0]  w_im,
    output logic signed [WIDTH-1:0] top_re,
    output logic signed [WIDTH-1:0] top_im,
    output logic signed [WIDTH-1:0] bot_re,
    output logic signed [WIDTH-1:0] bot_im
);
    localparam int PW  = WIDTH + TW_W + 1;
    localparam int PSW = WIDTH + 1;
    localparam int SW  = WIDTH + 2;

    logic signed [TW_W-1:0] wi;
    logic signed [PW-1:0]   pr_full;
    logic signed [PW-1:0]   pi_full;
    logic signed [PSW-1:0]  p_re;
    logic signed [PSW-1:0]  p_im;

    // Drop the Q1.(TW_W-1) fraction (floor) and keep WIDTH+1 bits.
    function automatic logic signed [PSW-1:0] scale_prod(input logic signed [PW-1:0] full);
        logic signed [PW-1:0] sh;
        sh = full >>> (TW_W - 1);
        return sh[PSW-1:0];
    endfunction

    // Halve a WIDTH+2 bit sum (floor) and truncate to WIDTH, no saturation.
    function automatic logic signed [WIDTH-1:0] half_trunc(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] sh;
        sh = s >>> 1;
        return sh[WIDTH-1:0];
    endfunction

    // Complex multiply b*W followed by the scaled sum and difference.
    always_comb begin
        wi      = conj_tw ? -w_im : w_im;
        pr_full = PW'(b_re) * PW'(w_re) - PW'(b_im) * PW'(wi);
        pi_full = PW'(b_re) * PW'(wi) + PW'(b_im) * PW'(w_re);
        p_re    = scale_prod(pr_full);
        p_im    = scale_prod(pi_full);
        top_re  = half_trunc(SW'(a_re) + SW'(p_re));
        top_im  = half_trunc(SW'(a_im) + SW'(p_im));
        bot_re  = half_trunc(SW'(a_re) - SW'(p_re));
        bot_im  = half_trunc(SW'(a_im) - SW'(p_im));
    end

endmodule

// File: rtl/ifft_seq.sv
// Sequential in-place radix-2 DIT inverse FFT with one shared butterfly.
module ifft_seq
    import fft_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SAMPLES = 8,
    parameter int TW_W    = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SAMPLES-1:0][WIDTH-1:0]   bin_re,
    input  logic [SAMPLES-1:0][WIDTH-1:0]   bin_im,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SAMPLES-1:0][WIDTH-1:0]   out_re,
    output logic [SAMPLES-1:0][WIDTH-1:0]   out_im
);
    localparam int LOG2N = log2_int(SAMPLES);
    localparam int BW    = LOG2N - 1;

    state_t state, next_state;
    logic   accept;
    logic   last_bfly;

    logic [LOG2N-1:0] stage;
    logic [BW-1:0]    bfly;

    logic signed [WIDTH-1:0] st_re [SAMPLES];
    logic signed [WIDTH-1:0] st_im [SAMPLES];

    logic [LOG2N-1:0] b_ext, mask, top_idx, bot_idx, tw_full;
    logic [BW-1:0]    tw_k;

    logic signed [TW_W-1:0]  rom_re [SAMPLES/2];
    logic signed [TW_W-1:0]  rom_im [SAMPLES/2];
    logic signed [WIDTH-1:0] top_re, top_im, bot_re, bot_im;

    // Forward twiddle table e^{-j2*pi*k/N}; the butterfly conjugates it.
    for (genvar i = 0; i < SAMPLES / 2; i++) begin : g_tw
        localparam cplx32_t           T     = twiddle(i, SAMPLES, TW_W);
        localparam logic signed [31:0] NEG_S = -T.im;
        assign rom_re[i] = T.re[TW_W-1:0];
        assign rom_im[i] = NEG_S[TW_W-1:0];
    end

    for (genvar i = 0; i < SAMPLES; i++) begin : g_out
        assign out_re[i] = st_re[i];
        assign out_im[i] = st_im[i];
    end

    assign last_bfly = (stage == LOG2N'(LOG2N - 1)) && (bfly == BW'(SAMPLES / 2 - 1));

    // Butterfly addressing for the current stage and butterfly index.
    always_comb begin
        b_ext   = {1'b0, bfly};
        mask    = (LOG2N'(1) << stage) - LOG2N'(1);
        top_idx = ((b_ext >> stage) << (stage + LOG2N'(1))) | (b_ext & mask);
        bot_idx = top_idx | (LOG2N'(1) << stage);
        tw_full = (b_ext & mask) << (LOG2N'(LOG2N - 1) - stage);
        tw_k    = tw_full[BW-1:0];
    end

    fft_butterfly #(
        .WIDTH (WIDTH),
        .TW_W  (TW_W)
    ) u_bfly (
        .conj_tw (1'b1),
        .a_re    (st_re[top_idx]),
        .a_im    (st_im[top_idx]),
        .b_re    (st_re[bot_idx]),
        .b_im    (st_im[bot_idx]),
        .w_re    (rom_re[tw_k]),
        .w_im    (rom_im[tw_k]),
        .top_re  (top_re),
        .top_im  (top_im),
        .bot_re  (bot_re),
        .bot_im  (bot_im)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // Next-state and handshake outputs.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    next_state = S_RUN;
                end
            end
            S_RUN: begin
                if (last_bfly) next_state = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Bit-reversed frame load, in-place butterfly write-back and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stage <= '0;
            bfly  <= '0;
            for (int k = 0; k < SAMPLES; k++) begin
                st_re[k] <= '0;
                st_im[k] <= '0;
            end
        end else if (accept) begin
            stage <= '0;
            bfly  <= '0;
            for (int k = 0; k < SAMPLES; k++) begin
                st_re[LOG2N'(bit_reverse(k, LOG2N))] <= bin_re[LOG2N'(k)];
                st_im[LOG2N'(bit_reverse(k, LOG2N))] <= bin_im[LOG2N'(k)];
            end
        end else if (state == S_RUN) begin
            st_re[top_idx] <= top_re;
            st_im[top_idx] <= top_im;
            st_re[bot_idx] <= bot_re;
            st_im[bot_idx] <= bot_im;
            bfly           <= bfly + BW'(1);
            if (bfly == BW'(SAMPLES / 2 - 1)) stage <= stage + LOG2N'(1);
        end
    end

endmodule

// File: doc/ifft_seq.md
# ifft_seq

Sequential radix-2 decimation-in-time inverse FFT. It accepts one frame of SAMPLES complex frequency bins, bit-reverse reorders them, and runs log2(SAMPLES) in-place stages with a single shared butterfly, scaling by 1/2 per stage for a total 1/N normalisation. It sits on the synthesis side of the FFT datapath: it consumes the parallel bin arrays the forward FFT produces and returns a time-domain frame to the sample path.

## Interface
- WIDTH, 16: signed two's-complement width of each real and imaginary component.
- SAMPLES, 8: points per frame; power of two, ≥ 4.
- TW_W, 16: twiddle width, signed Q1.(TW_W-1).
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-low; clears all state immediately.
- in_valid  in  1  input frame present on bin_re/bin_im.
- in_ready  out  1  block can accept a frame; high only in IDLE.
- bin_re  in  [WIDTH-1:0] [SAMPLES-1:0]  real part of bins X[k], natural order.
- bin_im  in  [WIDTH-1:0] [SAMPLES-1:0]  imaginary part of X[k].
- out_valid  out  1  time-domain frame valid; high only in DONE.
- out_ready  in  1  consumer accepts the frame.
- out_re  out  [WIDTH-1:0] [SAMPLES-1:0]  real part of x[n], natural order.
- out_im  out  [WIDTH-1:0] [SAMPLES-1:0]  imaginary part of x[n].

## Operation
- Working store: SAMPLES complex registers. out_re/out_im are driven directly from it.
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, store X[k] at bit-reversed address rev(k) (LOG2N bits), clear stage and bfly counters, go to RUN.
- RUN:
  - One butterfly per cycle; in_ready=0; in_valid is ignored.
  - Indexing for stage s (0..LOG2N-1) and butterfly b (0..SAMPLES/2-1):
    - h = 2^s
    - top = ((b>>s)·2h) + (b & (h-1))
    - bot = top + h
    - k = (b & (h-1)) << (LOG2N-1-s)
    - W = round((2^(TW_W-1)-1)·e^{+j2πk/SAMPLES}), i.e. the conjugate of the forward twiddle.
  - Arithmetic:
    - Complex product p = b·W at full WIDTH+TW_W precision, then arithmetic shift right by TW_W-1, truncated to WIDTH+1 bits.
    - top' = (a + p) >>> 1 and bot' = (a − p) >>> 1, each computed at WIDTH+2 bits and truncated to WIDTH. No saturation; the per-stage halving keeps in-range inputs from overflowing.
  - Both results are written back in place in the same cycle.
  - Counters: bfly increments each cycle; when it wraps from SAMPLES/2-1, stage increments.
  - The butterfly with stage=LOG2N-1 and bfly=SAMPLES/2-1 transitions to DONE.
- DONE:
  - out_valid=1; out_re/out_im are held stable.
  - On out_ready, go to IDLE.
  - in_ready stays 0 in DONE, so no frame can be accepted in the same cycle as the output handshake.
- Reset: asserting rst at any time, including mid-RUN, forces IDLE, zeroes the store and counters, and discards the partial frame. out_valid=0 and out_re/out_im=0 while reset is held.

## Timing
- Reset values: in_ready=1, out_valid=0, out_re=0, out_im=0.
- Accept edge is cycle 0. out_valid rises after LOG2N·SAMPLES/2 further edges: 12 edges for SAMPLES=8, 32 for 16.
- Throughput: one frame per LOG2N·SAMPLES/2 + 2 cycles when out_ready is held high.
- out_valid stays high, with data stable, for as long as out_ready is low.
- in_ready falls on the edge after acceptance and rises on the edge after the output handshake.

## Structure
- Package fft_pkg holds:
  - LOG2N derivation, via a function of SAMPLES.
  - bit_reverse function.
  - Twiddle constant function returning cos and sin in Q1.(TW_W-1).
  - State enum.
  - Complex struct type {re, im}.
- Sub-module fft_butterfly: combinational. Takes a, b and W; returns top' and bot' with the scaling and truncation rules above. It is shared with the forward FFT through a conj_tw select.
- The counters, bit-reverse load and in-place store stay in ifft_seq.

## Test plan
All tests use WIDTH=16, SAMPLES=8, TW_W=16.
- DC bin: X[0]=(800,0), all other bins 0 → every x[n]=(100,0) exactly; out_valid rises 12 cycles after accept.
- Single bin: X[1]=(800,0) → x[n]=100·e^{+j2πn/8}, within ±2 LSB. Check x[0]=(100,0), x[1]≈(71,71), x[2]≈(0,100), x[6]≈(0,−100). Confirms the conjugate twiddle direction.
- Backpressure: hold out_ready=0 for 20 cycles in DONE → out_valid and data stay stable and in_ready stays 0. Then pulse out_ready → IDLE next cycle; a back-to-back frame is accepted the following cycle.
- Ignored input: in_valid pulses with different data during RUN → results are unchanged from the original frame.
- Reset mid-frame: drop rst at RUN cycle 5 → outputs 0, in_ready=1 immediately. A fresh DC frame then yields the correct result.
- Round trip: the forward FFT of a random 8-sample frame, fed into ifft_seq with a final ×8, matches the original within ±LOG2N·2 LSB.
